// File: rtl/seg_scan_capture_pkg.sv
// Shared definitions for the 7-segment scan capture block: active-low segment
// patterns, blank code and the capture FSM state encoding.
package seg_scan_capture_pkg;

  // Patterns in active-low form (lit segment = 0), bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Output ports digit3..digit0 fix the largest supported digit count.
  localparam int MAX_DIGITS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/seg_scan_capture_seg7_to_bcd.sv
// Combinational 7-segment pattern to BCD decoder; blank decodes to BLANK_CODE.
// Any pattern outside 0-9/blank reports valid=0.
module seg7_to_bcd
  import seg_scan_capture_pkg::*;
#(
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic [6:0] seg_in,
  output logic       valid,
  output logic [3:0] bcd
);

  logic [6:0] pat;

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    valid = 1'b1;
    bcd   = BLANK_CODE;
    pat   = (SEG_ACTIVE_LOW != 0) ? seg_in : ~seg_in;
    case (pat)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: bcd = BLANK_CODE;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive-side checker for a multiplexed 7-segment bus: rebuilds the digit value
// and flags decode, select and stall faults. Optional err_cnt port: SEG_SCAN_CAPTURE_ERRCNT_EN.
module seg_scan_capture
  import seg_scan_capture_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,   // at most MAX_DIGITS
  parameter int SEL_W          = 6,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int TIMEOUT_CYC    = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seg_clk_in,
  input  logic [SEL_W-1:0] seg_sel_in,
  input  logic [6:0]       seg_data_in,
  output logic [3:0]       digit3,
  output logic [3:0]       digit2,
  output logic [3:0]       digit1,
  output logic [3:0]       digit0,
  output logic             digits_valid,
  output logic             frame_valid,
  output logic             seg_err,
  output logic             sel_err,
`ifdef SEG_SCAN_CAPTURE_ERRCNT_EN
  output logic [7:0]       err_cnt,
`endif
  output logic             timeout
);

  localparam int             CNT_W       = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  logic             s0_clk_q, s1_clk_q;
  logic [SEL_W-1:0] s0_sel_q;
  logic [6:0]       s0_data_q;

  state_e                state_q, state_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [3:0]            shadow_q [MAX_DIGITS];
  logic [3:0]            shadow_d [MAX_DIGITS];
  logic [3:0]            digit_q  [MAX_DIGITS];
  logic [3:0]            digit_d  [MAX_DIGITS];
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic digits_valid_q, digits_valid_d;
  logic frame_valid_q, frame_valid_d;
  logic seg_err_q, seg_err_d;
  logic sel_err_q, sel_err_d;
  logic timeout_q, timeout_d;

  logic                  scan_edge;
  logic [SEL_W-1:0]      sel_act;
  logic [NUM_DIGITS-1:0] hit;
  logic                  dec_valid;
  logic [3:0]            dec_bcd;
  logic                  accept, bad, complete, stall;

  seg7_to_bcd #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec (
    .seg_in (s0_data_q),
    .valid  (dec_valid),
    .bcd    (dec_bcd)
  );

  always_comb begin
    scan_edge = s0_clk_q & ~s1_clk_q;
    sel_act   = (SEL_ACTIVE_LOW != 0) ? ~s0_sel_q : s0_sel_q;
    hit       = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      hit[k] = scan_edge && (sel_act == (SEL_W'(1) << k));
    end
    accept   = (|hit) && dec_valid;
    bad      = (|hit) && !dec_valid;
    complete = (state_q == SCAN) && (&mask_q);
    // An accepted sample restarts the stall window, so it always beats a timeout.
    stall    = (state_q == SCAN) && !complete && !accept && (cnt_q == TIMEOUT_MAX);
  end

  always_comb begin
    state_d        = state_q;
    mask_d         = (complete || stall) ? '0 : mask_q;
    shadow_d       = shadow_q;
    digit_d        = digit_q;
    cnt_d          = cnt_q;
    digits_valid_d = digits_valid_q;
    frame_valid_d  = complete;
    seg_err_d      = bad;
    sel_err_d      = scan_edge && ($countones(sel_act) > 1);
    timeout_d      = stall;

    if (accept) mask_d = mask_d | hit;
    if (bad)    mask_d = mask_d & ~hit;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (accept && hit[k]) shadow_d[k] = dec_bcd;
    end

    if (complete) begin
      for (int k = 0; k < NUM_DIGITS; k++) digit_d[k] = shadow_q[k];
      digits_valid_d = 1'b1;
    end

    if (accept || stall)                          cnt_d = '0;
    else if (state_q == SCAN && cnt_q != TIMEOUT_MAX) cnt_d = cnt_q + 1'b1;

    case (state_q)
      IDLE:    if (accept) state_d = SCAN;
      SCAN:    if (stall) begin
                 state_d        = IDLE;
                 digits_valid_d = 1'b0;
               end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_clk_q       <= 1'b0;
      s1_clk_q       <= 1'b0;
      s0_sel_q       <= '0;
      s0_data_q      <= '0;
      state_q        <= IDLE;
      mask_q         <= '0;
      cnt_q          <= '0;
      digits_valid_q <= 1'b0;
      frame_valid_q  <= 1'b0;
      seg_err_q      <= 1'b0;
      sel_err_q      <= 1'b0;
      timeout_q      <= 1'b0;
      // NOTE: shadow and digit registers are reset because the outputs must read 0 after reset.
      for (int k = 0; k < MAX_DIGITS; k++) begin
        shadow_q[k] <= '0;
        digit_q[k]  <= '0;
      end
    end else begin
      s0_clk_q       <= seg_clk_in;
      s1_clk_q       <= s0_clk_q;
      s0_sel_q       <= seg_sel_in;
      s0_data_q      <= seg_data_in;
      state_q        <= state_d;
      mask_q         <= mask_d;
      cnt_q          <= cnt_d;
      digits_valid_q <= digits_valid_d;
      frame_valid_q  <= frame_valid_d;
      seg_err_q      <= seg_err_d;
      sel_err_q      <= sel_err_d;
      timeout_q      <= timeout_d;
      shadow_q       <= shadow_d;
      digit_q        <= digit_d;
    end
  end

`ifdef SEG_SCAN_CAPTURE_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((seg_err_d || sel_err_d || timeout_d) && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

  assign digit3       = digit_q[3];
  assign digit2       = digit_q[2];
  assign digit1       = digit_q[1];
  assign digit0       = digit_q[0];
  assign digits_valid = digits_valid_q;
  assign frame_valid  = frame_valid_q;
  assign seg_err      = seg_err_q;
  assign sel_err      = sel_err_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: table of scan samples with expected pulses and
// digits, plus hand sequences for stall timeout, mid-scan reset and the error counter.
module tb_seg_scan_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       seg_clk_in;
  logic [5:0] seg_sel_in;
  logic [6:0] seg_data_in;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic       digits_valid, frame_valid, seg_err, sel_err, timeout;
`ifdef SEG_SCAN_CAPTURE_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  always #5 clk = ~clk;

  seg_scan_capture dut (
    .clk          (clk),
    .rst          (rst),
    .seg_clk_in   (seg_clk_in),
    .seg_sel_in   (seg_sel_in),
    .seg_data_in  (seg_data_in),
    .digit3       (digit3),
    .digit2       (digit2),
    .digit1       (digit1),
    .digit0       (digit0),
    .digits_valid (digits_valid),
    .frame_valid  (frame_valid),
    .seg_err      (seg_err),
    .sel_err      (sel_err),
`ifdef SEG_SCAN_CAPTURE_ERRCNT_EN
    .err_cnt      (err_cnt),
`endif
    .timeout      (timeout)
  );

  int checks = 0;
  int errors = 0;

  int fv_cnt = 0, se_cnt = 0, sl_cnt = 0, to_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) fv_cnt++;
      if (seg_err)     se_cnt++;
      if (sel_err)     sl_cnt++;
      if (timeout)     to_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One scan slot: select/data with seg_clk high for 2 clk, then low for 2 clk.
  task automatic send(input logic [5:0] sel, input logic [6:0] data);
    @(posedge clk); #1;
    seg_sel_in  = sel;
    seg_data_in = data;
    seg_clk_in  = 1'b1;
    repeat (2) @(posedge clk);
    #1 seg_clk_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst        = 1'b1;
    seg_clk_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic [5:0]  sel;
    logic [6:0]  data;
    int          fv;
    int          se;
    int          sl;
    logic [15:0] digits;
    logic        valid;
  } vec_t;

  vec_t vecs [16];

  task automatic run_vecs(input int first, input int last);
    int fv0, se0, sl0;
    for (int i = first; i <= last; i++) begin
      fv0 = fv_cnt; se0 = se_cnt; sl0 = sl_cnt;
      send(vecs[i].sel, vecs[i].data);
      @(negedge clk);
      check($sformatf("v%0d frame_valid", i), fv_cnt - fv0, vecs[i].fv);
      check($sformatf("v%0d seg_err", i), se_cnt - se0, vecs[i].se);
      check($sformatf("v%0d sel_err", i), sl_cnt - sl0, vecs[i].sl);
      check($sformatf("v%0d digits", i), {digit3, digit2, digit1, digit0}, vecs[i].digits);
      check($sformatf("v%0d digits_valid", i), digits_valid, vecs[i].valid);
    end
  endtask

  localparam logic [5:0] IDX0 = 6'b111110, IDX1 = 6'b111101, IDX2 = 6'b111011, IDX3 = 6'b110111;

  initial begin
    int n, fv0, to0;
    bit seen;

    rst         = 1'b1;
    seg_clk_in  = 1'b0;
    seg_sel_in  = 6'b111111;
    seg_data_in = 7'h7F;

    vecs[0]  = '{IDX3, 7'h10, 0, 0, 0, 16'h0000, 1'b0};
    vecs[1]  = '{IDX2, 7'h02, 0, 0, 0, 16'h0000, 1'b0};
    vecs[2]  = '{IDX1, 7'h78, 0, 0, 0, 16'h0000, 1'b0};
    vecs[3]  = '{IDX0, 7'h12, 1, 0, 0, 16'h9675, 1'b1};
    vecs[4]  = '{IDX1, 7'h7E, 0, 1, 0, 16'h9675, 1'b1};
    vecs[5]  = '{IDX3, 7'h10, 0, 0, 0, 16'h9675, 1'b1};
    vecs[6]  = '{IDX2, 7'h02, 0, 0, 0, 16'h9675, 1'b1};
    vecs[7]  = '{IDX0, 7'h12, 0, 0, 0, 16'h9675, 1'b1};
    vecs[8]  = '{6'b111100, 7'h78, 0, 0, 1, 16'h9675, 1'b1};
    vecs[9]  = '{6'b111111, 7'h00, 0, 0, 0, 16'h9675, 1'b1};
    vecs[10] = '{6'b011111, 7'h78, 0, 0, 0, 16'h9675, 1'b1};
    vecs[11] = '{IDX1, 7'h78, 1, 0, 0, 16'h9675, 1'b1};
    vecs[12] = '{IDX3, 7'h7F, 0, 0, 0, 16'h9675, 1'b0};
    vecs[13] = '{IDX2, 7'h40, 0, 0, 0, 16'h9675, 1'b0};
    vecs[14] = '{IDX1, 7'h40, 0, 0, 0, 16'h9675, 1'b0};
    vecs[15] = '{IDX0, 7'h79, 1, 0, 0, 16'hF001, 1'b1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset digits", {digit3, digit2, digit1, digit0}, 16'h0000);
    check("reset flags", {digits_valid, frame_valid, seg_err, sel_err, timeout}, 5'b0);

    run_vecs(0, 11);

    // Stall mid-scan: two digits then no more scan clock edges.
    send(IDX3, 7'h10);
    send(IDX2, 7'h02);
    to0  = to_cnt;
    n    = 0;
    seen = 1'b0;
    while (n < 1200 && !seen) begin
      @(negedge clk);
      n++;
      if (timeout) seen = 1'b1;
    end
    check("timeout seen", seen, 1'b1);
    check("timeout not early", (n >= 1000), 1'b1);
    check("timeout not late", (n <= 1030), 1'b1);
    check("timeout digits_valid", digits_valid, 1'b0);
    check("timeout digits hold", {digit3, digit2, digit1, digit0}, 16'h9675);
    repeat (3) @(negedge clk);
    check("timeout single pulse", to_cnt - to0, 1);

    run_vecs(12, 15);

    // Reset mid-scan clears outputs and the partial mask.
    send(IDX3, 7'h10);
    send(IDX2, 7'h02);
    do_reset();
    @(negedge clk);
    check("midreset digits", {digit3, digit2, digit1, digit0}, 16'h0000);
    check("midreset flags", {digits_valid, frame_valid, seg_err, sel_err, timeout}, 5'b0);
    fv0 = fv_cnt;
    send(IDX1, 7'h78);
    send(IDX0, 7'h12);
    @(negedge clk);
    check("midreset no frame", fv_cnt - fv0, 0);

`ifdef SEG_SCAN_CAPTURE_ERRCNT_EN
    do_reset();
    @(negedge clk);
    check("err_cnt reset", err_cnt, 8'd0);
    for (int i = 0; i < 300; i++) begin
      send(IDX1, 7'h7E);
      if (i == 9) begin
        @(negedge clk);
        check("err_cnt after 10", err_cnt, 8'd10);
      end
    end
    @(negedge clk);
    check("err_cnt saturated", err_cnt, 8'd255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
